// File: rtl/mem_pkg.sv
// Shared size encodings, sequencer state type and byte-enable helpers for mem_access_seq.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StWait,
        StResp
    } state_e;

    // Misaligned low address bits are ignored; the reserved size behaves as a word.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_RSVD) ||
               ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Combinational byte-enable and misalignment decode from access size and address[1:0].
// The misalign trap exists only when MEM_ALIGN_TRAP_EN is defined.
module mem_be_gen
    import mem_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_be,
    output logic       o_misalign
);

    assign o_be = be_gen(i_size, i_addr_lo);

`ifdef MEM_ALIGN_TRAP_EN
    assign o_misalign = is_misaligned(i_size, i_addr_lo);
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer in front of the 4 KB data memory: IDLE -> ACC -> [WAIT] -> RESP.
// Define MEM_ALIGN_TRAP_EN to reject misaligned/reserved-size requests with resp_err.
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int unsigned DM_AW  = 10,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_din,
    output logic              dm_wr,
    output logic              dm_op,
    input  logic [31:0]       dm_dout
);

    state_e           r_state;
    logic             r_is_wr;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [31:0]      r_rdata;
    logic [DM_AW-1:0] r_dm_addr;
    logic [3:0]       r_dm_be;
    logic [31:0]      r_dm_din;
    logic             r_dm_wr;
    logic             r_dm_op;

    logic [3:0]       w_be;
    logic             w_misalign;
    logic             w_unused_addr;

    mem_be_gen u_be_gen (
        .i_size     (req_size),
        .i_addr_lo  (req_addr[1:0]),
        .o_be       (w_be),
        .o_misalign (w_misalign)
    );

    // Address bits above the 4 KB window do not reach the memory.
    assign w_unused_addr = ^req_addr[ADDR_W-1:DM_AW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_is_wr      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
            r_dm_addr    <= '0;
            r_dm_be      <= 4'b0000;
            r_dm_din     <= '0;
            r_dm_wr      <= 1'b0;
            r_dm_op      <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_is_wr   <= req_wr;
                        r_dm_addr <= req_addr[DM_AW+1:2];
                        r_dm_din  <= req_wdata;
                        r_dm_op   <= req_unsigned;
                        if (w_misalign) begin
                            // Trapped request: answer next cycle without touching memory.
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state <= StAcc;
                            r_dm_be <= w_be;
                            r_dm_wr <= req_wr;
                        end
                    end
                end
                StAcc: begin
                    r_dm_wr <= 1'b0;
                    if (r_is_wr) begin
                        r_dm_be      <= 4'b0000;
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                    end else begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    r_rdata      <= dm_dout;
                    r_dm_be      <= 4'b0000;
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                end
                StResp: begin
                    r_resp_err <= 1'b0;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rdata;
    assign dm_addr    = r_dm_addr;
    assign dm_be      = r_dm_be;
    assign dm_din     = r_dm_din;
    assign dm_wr      = r_dm_wr;
    assign dm_op      = r_dm_op;

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
Load/store sequencer that sits directly upstream of the 4 KB data memory (dm_4k) in the multicycle CPU.
- Accepts one load/store request at a time from the control FSM / datapath.
- Derives the word index, byte enables, write strobe and sign/zero-extension select for the memory, and sequences the access around the memory's one-cycle registered read.
- Captures the extended load result (the MDR role) and returns a single-cycle completion pulse, flagging misaligned accesses when the trap is compiled in.

Parameters:
DM_AW, 10, word-index width driven to the memory (1024 words).
ADDR_W, 32, width of the byte address from the datapath.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request strobe; accepted when req_ready=1
req_ready  out  1  high only in IDLE
req_wr  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  1=zero-extend load (lbu/lhu), 0=sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, low-lane justified (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; 1=misaligned/illegal, no access performed
resp_rdata  out  32  extended load data; holds until the next successful load completes
dm_addr  out  DM_AW  req_addr[DM_AW+1:2]
dm_be  out  4  byte enables
dm_din  out  32  = latched req_wdata, unshifted (memory does lane placement)
dm_wr  out  1  write strobe
dm_op  out  1  = latched req_unsigned
dm_dout  in  32  memory read data, valid the cycle after dm_addr/dm_be are presented

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dm_wr=0, dm_be=0000, dm_addr=0, dm_din=0, dm_op=0.
- All dm_* outputs are registered. In IDLE and RESP: dm_be=0000 and dm_wr=0, so the memory neither writes nor updates its read data.
- Byte-enable map:
  - byte, by addr[1:0]: 00→0001, 01→0010, 10→0100, 11→1000
  - half, by addr[1]: 0→0011, 1→1100
  - word: 1111
- FSM states: IDLE, ACC, WAIT, RESP. Cycle T is the acceptance cycle.
  - IDLE: req_valid=1 latches all request fields and computes be/misalign. If legal → ACC. If illegal (trap on) → RESP with err.
  - ACC (T+1): dm_addr/be/op/din are presented. dm_wr=1 for exactly this cycle on a store. Store → RESP; load → WAIT.
  - WAIT (T+2, load only): dm_addr/be/op are held. dm_dout is valid; resp_rdata <= dm_dout at the end of the cycle.
  - RESP: resp_valid=1 for one cycle. Store completes at T+2, load at T+3, error at T+1. Next state is always IDLE.
- There is no response backpressure. req_valid is ignored outside IDLE.
- Back-to-back: the earliest next acceptance is the cycle after RESP.
- Stores never modify resp_rdata. Error responses leave resp_rdata unchanged.
- Reset mid-operation: FSM returns to IDLE and dm_wr/dm_be clear asynchronously. A store with rst asserted before the ACC rising edge must not write. No resp_valid is produced for an aborted request.

Optional Feature:
MEM_ALIGN_TRAP_EN
- Defined: a misaligned request (half with addr[0]=1; word with addr[1:0]≠00) or req_size=11 gives resp_err=1 at T+1, with no memory access (dm_wr=0, dm_be=0000 throughout).
- Undefined: no trap and resp_err is tied 0. Misaligned low bits are ignored: half uses addr[1] only, word uses be=1111, and size 11 is treated as word.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - FSM state enum
  - be_gen function
  - misalign predicate
- Sub-module mem_be_gen (combinational: size, addr[1:0] → be, misalign) is natural and reused by the datapath decoder.

Test Plan:
- Store word 0xDEADBEEF @0x10 → T+1: dm_addr=4, dm_be=1111, dm_wr=1 for one cycle; T+2: resp_valid=1, resp_err=0.
- Load byte signed @0x13 (word 0xDEADBEEF) → dm_be=1000, dm_op=0; T+3: resp_rdata=0xFFFFFFDE. Unsigned @0x12 → dm_be=0100, dm_op=1, resp_rdata=0x000000AD.
- Load half signed @0x12 → dm_be=1100, resp_rdata=0xFFFFDEAD. sh 0x1234 @0x10, then lhu @0x10 → 0x00001234.
- Load word @0x11:
  - with MEM_ALIGN_TRAP_EN: T+1 resp_valid=1, resp_err=1, no dm_be activity, resp_rdata unchanged.
  - without: reads word 4, resp_err=0.
- rst pulsed during ACC of store 0xCAFEF00D @0x20, before the edge → dm_wr drops immediately, no resp_valid, later load @0x20 returns prior contents; req_ready=1 after release.
- Back-to-back store then load, req_valid held high → second request accepted in the cycle after the first RESP; req_valid ignored in ACC/WAIT/RESP.
